if_stage: RTL and testbench



---
 rtl/if_stage_pkg.sv | 6 +
 rtl/if_stage_if_id_reg.sv | 21 ++
 rtl/if_stage.sv | 93 +++++++++
 tb/tb_if_stage.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// if_stage_pkg: fetch-state encodings and fetch constants shared by the IF stage.
package if_stage_pkg;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD, S_DRAIN} fetch_state_t;
endpackage

// File: rtl/if_stage_if_id_reg.sv
// if_id_reg: IF/ID pipeline register {pc, inst, valid}, flush beats load.
// Ports: clk, rstn (async active-low); load/flush controls; pc/inst data in;
// q_pc/q_inst/q_valid register contents out.
module if_id_reg
  import if_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        load,
  input  logic        flush,
  input  logic [31:0] pc,
  input  logic [31:0] inst,
  output logic [31:0] q_pc,
  output logic [31:0] q_inst,
  output logic        q_valid
);
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) {q_pc, q_inst, q_valid} <= {32'h0, NOP_INST, 1'b0};
    else if (flush) {q_pc, q_inst, q_valid} <= {32'h0, NOP_INST, 1'b0};
    else if (load) {q_pc, q_inst, q_valid} <= {pc, inst, 1'b1};
endmodule

// File: rtl/if_stage.sv
// if_stage: instruction fetch with one outstanding imem request, skid buffer and IF/ID register.
// Ports: clk, rstn (async active-low); pc_o/npc_i to and from next-PC logic;
// redirect_i/stall_i front-end control; imem_req/addr/gnt/rvalid/rdata memory
// handshake; if_id_pc/inst/valid pipeline register outputs.
module if_stage
  import if_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  output logic [31:0] pc_o,
  input  logic [31:0] npc_i,
  input  logic        redirect_i,
  input  logic        stall_i,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_inst,
  output logic        if_id_valid
);
  fetch_state_t state, state_n;
  logic [31:0] pc, pc_n, skid, skid_n, load_inst;
  logic load;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= S_IDLE;
      pc    <= RESET_PC;
      skid  <= '0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      skid  <= skid_n;
    end
  // Redirect is checked first in every state so it overrides stall and rvalid.
  always_comb begin
    state_n   = state;
    pc_n      = pc;
    skid_n    = skid;
    load      = 1'b0;
    load_inst = imem_rdata;
    case (state)
      S_IDLE: state_n = S_REQ;
      S_REQ: begin
        if (redirect_i) pc_n = npc_i;
        if (imem_gnt) state_n = redirect_i ? S_DRAIN : S_WAIT;
      end
      S_WAIT:
        if (redirect_i) begin
          pc_n    = npc_i;
          state_n = imem_rvalid ? S_REQ : S_DRAIN;
        end else if (imem_rvalid && stall_i) begin
          skid_n  = imem_rdata;
          state_n = S_HOLD;
        end else if (imem_rvalid) begin
          load    = 1'b1;
          pc_n    = npc_i;
          state_n = S_REQ;
        end
      S_HOLD:
        if (redirect_i) begin
          pc_n    = npc_i;
          skid_n  = '0;
          state_n = S_REQ;
        end else if (!stall_i) begin
          load      = 1'b1;
          load_inst = skid;
          pc_n      = npc_i;
          state_n   = S_REQ;
        end
      S_DRAIN: begin
        if (redirect_i) pc_n = npc_i;
        if (imem_rvalid) state_n = S_REQ;
      end
      default: state_n = S_IDLE;
    endcase
  end
  assign imem_req  = state == S_REQ;
  assign imem_addr = pc;
  assign pc_o      = pc;
  if_id_reg u_if_id (
    .clk    (clk),
    .rstn   (rstn),
    .load   (load),
    .flush  (redirect_i),
    .pc     (pc),
    .inst   (load_inst),
    .q_pc   (if_id_pc),
    .q_inst (if_id_inst),
    .q_valid(if_id_valid)
  );
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed checks of if_stage against a transaction-level fetch model.
module tb_if_stage;
  logic clk = 1'b0, rstn = 1'b0;
  logic [31:0] pc_o, npc_i = 32'h0, imem_addr, imem_rdata, if_id_pc, if_id_inst;
  logic redirect_i = 1'b0, stall_i = 1'b0, imem_req, imem_gnt, imem_rvalid, if_id_valid;
  logic gnt_on = 1'b1;
  logic [31:0] tgt = 32'h0;
  int lat = 1;
  int vecs = 0, errs = 0;

  if_stage dut (
    .clk(clk), .rstn(rstn), .pc_o(pc_o), .npc_i(npc_i), .redirect_i(redirect_i),
    .stall_i(stall_i), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .if_id_pc(if_id_pc),
    .if_id_inst(if_id_inst), .if_id_valid(if_id_valid)
  );

  always #5 clk = ~clk;

  // Instruction memory: grants when enabled, answers lat cycles after the grant.
  logic pend;
  int cnt;
  logic [31:0] raddr;
  assign imem_gnt    = gnt_on;
  assign imem_rvalid = pend && cnt == 1;
  assign imem_rdata  = {16'hC0DE, raddr[15:0]};
  always @(posedge clk or negedge rstn)
    if (!rstn) begin
      pend <= 1'b0; cnt <= 0; raddr <= 32'h0;
    end else if (imem_req && imem_gnt) begin
      pend <= 1'b1; cnt <= lat; raddr <= imem_addr;
    end else if (pend) begin
      if (cnt == 1) pend <= 1'b0;
      else cnt <= cnt - 1;
    end

  // Model: tracks fetch as "booting / request outstanding / outstanding one is
  // wrong-path / buffered word" rather than as named states.
  logic m_boot, m_out, m_drop, m_bufv, m_ivld;
  logic [31:0] m_pc, m_buf, m_ipc, m_iinst;
  int cyc = 0;
  logic [31:0] g_q[$], lp_q[$], li_q[$];
  int lc_q[$];

  function automatic logic m_req();
    return !m_boot && !m_out && !m_bufv;
  endfunction

  task automatic m_load(input logic [31:0] w);
    m_ipc = m_pc; m_iinst = w; m_ivld = 1'b1;
    lp_q.push_back(m_pc); li_q.push_back(w); lc_q.push_back(cyc);
    m_pc = npc_i;
  endtask

  initial forever begin
    logic g;
    @(posedge clk or negedge rstn);
    if (!rstn) begin
      m_boot = 1'b1; m_out = 1'b0; m_drop = 1'b0; m_bufv = 1'b0; m_buf = 32'h0;
      m_pc = 32'h0; m_ipc = 32'h0; m_iinst = 32'h13; m_ivld = 1'b0;
    end else begin
      cyc++;
      g = m_req() && imem_gnt;
      if (g) g_q.push_back(m_pc);
      if (redirect_i) begin
        m_ipc = 32'h0; m_iinst = 32'h13; m_ivld = 1'b0;
        if (!m_boot) m_pc = npc_i;
        m_bufv = 1'b0;
        if (g) begin m_out = 1'b1; m_drop = 1'b1; end
        else if (m_out) begin m_out = !imem_rvalid; m_drop = !imem_rvalid; end
      end else if (g) begin
        m_out = 1'b1; m_drop = 1'b0;
      end else if (m_out && imem_rvalid) begin
        m_out = 1'b0;
        if (m_drop) m_drop = 1'b0;
        else if (stall_i) begin m_bufv = 1'b1; m_buf = imem_rdata; end
        else m_load(imem_rdata);
      end else if (m_bufv && !stall_i) begin
        m_load(m_buf); m_bufv = 1'b0;
      end
      m_boot = 1'b0;
    end
  end

  // Next-PC logic stand-in: sequential PC+4 from the model, or the redirect target.
  initial forever begin
    @(negedge clk);
    #1 npc_i = redirect_i ? tgt : m_pc + 32'd4;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    #2;
    chk("pc_o", pc_o, m_pc);
    chk("imem_addr", imem_addr, m_pc);
    chk("imem_req", {31'h0, imem_req}, {31'h0, m_req()});
    chk("if_id_pc", if_id_pc, m_ipc);
    chk("if_id_inst", if_id_inst, m_iinst);
    chk("if_id_valid", {31'h0, if_id_valid}, {31'h0, m_ivld});
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic reset_dut();
    rstn = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; gnt_on = 1'b1; lat = 1;
    tick(2);
    g_q.delete(); lp_q.delete(); li_q.delete(); lc_q.delete();
    rstn = 1'b1;
  endtask

  initial begin
    // Back-to-back fetch with a one-cycle memory.
    reset_dut();
    chk("rst_req", {31'h0, imem_req}, 32'h0);
    chk("rst_inst", if_id_inst, 32'h13);
    tick(1);
    chk("first_req", {31'h0, imem_req}, 32'h1);
    tick(6);
    chk("grant0", g_q.size() > 0 ? g_q[0] : 32'hX, 32'h0);
    chk("grant1", g_q.size() > 1 ? g_q[1] : 32'hX, 32'h4);
    chk("grant2", g_q.size() > 2 ? g_q[2] : 32'hX, 32'h8);
    chk("load_pc2", lp_q.size() > 2 ? lp_q[2] : 32'hX, 32'h8);
    chk("load_inst1", li_q.size() > 1 ? li_q[1] : 32'hX, 32'hC0DE0004);
    chk("load_gap", lc_q.size() > 1 ? lc_q[1] - lc_q[0] : -1, 32'd2);
    chk("seq_ifid_pc", if_id_pc, 32'h8);

    // Stall across the response: word is held in the skid buffer.
    reset_dut();
    tick(1);
    stall_i = 1'b1;
    tick(3);
    chk("stall_pc", pc_o, 32'h0);
    chk("stall_valid", {31'h0, if_id_valid}, 32'h0);
    chk("stall_req", {31'h0, imem_req}, 32'h0);
    stall_i = 1'b0;
    tick(1);
    chk("unstall_pc", if_id_pc, 32'h0);
    chk("unstall_inst", if_id_inst, 32'hC0DE0000);
    chk("unstall_pc_o", pc_o, 32'h4);

    // Redirect in WAIT, response arrives two cycles later and is dropped.
    reset_dut();
    lat = 3;
    tick(2);
    redirect_i = 1'b1; tgt = 32'h100;
    tick(1);
    redirect_i = 1'b0; lat = 1;
    chk("rw_pc", pc_o, 32'h100);
    chk("rw_valid", {31'h0, if_id_valid}, 32'h0);
    tick(2);
    chk("rw_req", {31'h0, imem_req}, 32'h1);
    chk("rw_addr", imem_addr, 32'h100);
    tick(2);
    chk("rw_ifid_pc", if_id_pc, 32'h100);
    chk("rw_ifid_inst", if_id_inst, 32'hC0DE0100);

    // Redirect together with the grant: wrong-path word is drained.
    reset_dut();
    tick(1);
    redirect_i = 1'b1; tgt = 32'h200;
    tick(1);
    redirect_i = 1'b0;
    chk("rg_pc", pc_o, 32'h200);
    chk("rg_req", {31'h0, imem_req}, 32'h0);
    tick(1);
    chk("rg_addr", imem_addr, 32'h200);
    chk("rg_valid", {31'h0, if_id_valid}, 32'h0);
    tick(2);
    chk("rg_ifid_pc", if_id_pc, 32'h200);
    chk("rg_ifid_inst", if_id_inst, 32'hC0DE0200);
    tick(1);
    // Asynchronous reset in the middle of WAIT.
    #3 rstn = 1'b0;
    #1;
    chk("ar_pc", pc_o, 32'h0);
    chk("ar_req", {31'h0, imem_req}, 32'h0);
    chk("ar_ifid_pc", if_id_pc, 32'h0);
    chk("ar_ifid_inst", if_id_inst, 32'h13);
    chk("ar_valid", {31'h0, if_id_valid}, 32'h0);

    // Redirect, stall and rvalid together: redirect wins.
    reset_dut();
    tick(3);
    chk("rs_pre_valid", {31'h0, if_id_valid}, 32'h1);
    tick(1);
    redirect_i = 1'b1; stall_i = 1'b1; tgt = 32'h300;
    tick(1);
    redirect_i = 1'b0; stall_i = 1'b0;
    chk("rs_inst", if_id_inst, 32'h13);
    chk("rs_valid", {31'h0, if_id_valid}, 32'h0);
    chk("rs_pc", pc_o, 32'h300);
    chk("rs_req", {31'h0, imem_req}, 32'h1);
    tick(2);
    chk("rs_ifid_pc", if_id_pc, 32'h300);

    // Redirect in REQ without grant, then PC wraps past 2^32.
    reset_dut();
    gnt_on = 1'b0;
    tick(1);
    redirect_i = 1'b1; tgt = 32'hFFFF_FFFC;
    tick(1);
    redirect_i = 1'b0;
    chk("ng_req", {31'h0, imem_req}, 32'h1);
    chk("ng_addr", imem_addr, 32'hFFFF_FFFC);
    gnt_on = 1'b1;
    tick(2);
    chk("wrap_ifid_pc", if_id_pc, 32'hFFFF_FFFC);
    chk("wrap_pc", pc_o, 32'h0);

    // Mixed pattern of stalls, grant gaps, latencies and redirects.
    reset_dut();
    for (int i = 0; i < 200; i++) begin
      stall_i = (i % 7) >= 5;
      gnt_on = (i % 5) != 3;
      redirect_i = (i % 13) == 6;
      tgt = 32'(i) << 4;
      lat = 1 + i % 3;
      tick(1);
    end
    redirect_i = 1'b0; stall_i = 1'b0;
    tick(4);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
